// File: rtl/clk_domain_gen.sv
// clk_domain_gen: NUM_CH run-time programmable, glitch-free clock dividers with stop and realign.
// Latency: every output except cfg_ready is a flop; a ratio change lands at the channel's next wrap.
// Backpressure: cfg_ready drops for a channel while its previous ratio change is still pending.
//
// Ports:
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   ch_en[NUM_CH]         per-channel run enable (1 = run)
//   sync_restart          one-cycle pulse; realigns all channels
//   cfg_valid/cfg_ready   ratio-change handshake; cfg_ch selects channel, cfg_div the ratio
//   cfg_err               one-cycle pulse after an accepted but illegal request
//   cfg_pending[NUM_CH]   ratio change waiting for the channel's next wrap
//   clk_out[NUM_CH]       divided clocks
//   tick[NUM_CH]          pulse in the first high cycle of each clk_out period
module clk_domain_gen #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic ch_ok;
    logic div_ok;
    logic cfg_acc;
    logic cfg_acc_ok;

    assign ch_ok      = int'(cfg_ch) < NUM_CH;
    assign div_ok     = cfg_div >= TWO;
    assign cfg_acc    = cfg_valid & cfg_ready;
    assign cfg_acc_ok = cfg_acc & ch_ok & div_ok;

    // Out-of-range channels are always ready so the illegal request can be
    // accepted and reported instead of stalling the requester forever.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_ch) == i) cfg_ready = ~cfg_pending[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cfg_err <= 1'b0;
        else       cfg_err <= cfg_acc & ~(ch_ok & div_ok);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_cur;
        logic [DIV_W-1:0] div_pend;
        logic [DIV_W-1:0] nxt_cnt;
        logic [DIV_W-1:0] nxt_div;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             at_last;
        logic             apply;
        logic             run;
        logic             acc;

        // cnt == N-1 marks the last cycle of a period; the wrap (or a hold,
        // when stopped) happens on the edge that leaves it.
        assign at_last = (cnt == div_cur - ONE);
        // A pending ratio is only ever taken at a period boundary, which is
        // what keeps ratio changes glitch-free.
        assign apply   = pend & (sync_restart | at_last);
        assign nxt_div = apply ? div_pend : div_cur;
        // Not running: restart, or a stopped channel parked on its last cycle.
        // Both park cnt at N-1 so the next running edge wraps and rises.
        assign run     = ~sync_restart & ~(at_last & ~ch_en[g]);
        assign nxt_cnt = !run    ? nxt_div - ONE :
                         at_last ? '0            : cnt + ONE;
        assign acc     = cfg_acc_ok & (int'(cfg_ch) == g);

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt      <= DEF_DIV - ONE;
                div_cur  <= DEF_DIV;
                div_pend <= DEF_DIV;
                pend     <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt     <= nxt_cnt;
                div_cur <= nxt_div;
                clk_q   <= run & (nxt_cnt < (nxt_div >> 1));
                tick_q  <= run & (nxt_cnt == '0);
                // acc needs pend == 0 and apply needs pend == 1, so they never
                // collide; an accept on a wrap or restart edge is therefore
                // held over to the following boundary.
                if (acc) begin
                    pend     <= 1'b1;
                    div_pend <= cfg_div;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign cfg_pending[g] = pend;
        assign clk_out[g]     = clk_q;
        assign tick[g]        = tick_q;
    end

endmodule

// File: tb/tb_clk_domain_gen.sv
// tb_clk_domain_gen: directed bench for clk_domain_gen with a period-queue reference model.
// Latency: the model updates on each rising edge; outputs are compared on every falling edge.
// Backpressure: the model derives cfg_ready from its own pending flags.
module tb_clk_domain_gen;

    localparam int NCH = 4;
    localparam int CHW = 3;
    localparam int DW  = 8;
    localparam int DEF = 4;

    logic           clock;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           sync_restart;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_err;
    logic [NCH-1:0] cfg_pending;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int n_cmp = 0;
    int n_bad = 0;

    clk_domain_gen #(
        .NUM_CH(NCH), .CH_W(CHW), .DIV_W(DW), .DEFAULT_DIV(DEF)
    ) dut (
        .clock(clock), .reset(reset), .ch_en(ch_en), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .cfg_pending(cfg_pending), .clk_out(clk_out), .tick(tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel holds a queue of the (clk, tick) values still to come in
    // its current period. An empty queue means the period is over: the next
    // enabled edge starts a fresh period (taking any pending ratio first), a
    // disabled edge outputs low.
    logic [1:0]     mq [NCH][$];
    int             m_div  [NCH];
    int             m_pdiv [NCH];
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;
    logic           m_err;
    bit             started = 1'b0;

    function automatic logic model_ready(input logic [CHW-1:0] c);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NCH; i++) if (int'(c) == i) r = ~m_pend[i];
        return r;
    endfunction

    always @(posedge clock) begin
        logic       rdy;
        logic       acc;
        logic       legal;
        logic [1:0] w;
        started = 1'b1;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                mq[i].delete();
                m_div[i]  = DEF;
                m_pdiv[i] = DEF;
            end
            m_pend = '0;
            m_clk  = '0;
            m_tick = '0;
            m_err  = 1'b0;
        end else begin
            rdy   = model_ready(cfg_ch);
            acc   = cfg_valid && rdy;
            legal = (int'(cfg_div) >= 2) && (int'(cfg_ch) < NCH);
            m_err = acc && !legal;
            for (int i = 0; i < NCH; i++) begin
                if ((sync_restart || mq[i].size() == 0) && m_pend[i]) begin
                    m_div[i]  = m_pdiv[i];
                    m_pend[i] = 1'b0;
                end
                if (sync_restart) begin
                    mq[i].delete();
                    m_clk[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                end else begin
                    if (mq[i].size() == 0 && ch_en[i]) begin
                        for (int k = 0; k < m_div[i]; k++)
                            mq[i].push_back({k < m_div[i] / 2, k == 0});
                    end
                    if (mq[i].size() == 0) begin
                        m_clk[i]  = 1'b0;
                        m_tick[i] = 1'b0;
                    end else begin
                        w = mq[i].pop_front();
                        m_clk[i]  = w[1];
                        m_tick[i] = w[0];
                    end
                end
                if (acc && legal && int'(cfg_ch) == i) begin
                    m_pend[i] = 1'b1;
                    m_pdiv[i] = int'(cfg_div);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (started) begin
            chk("clk_out",     32'(clk_out),     32'(m_clk));
            chk("tick",        32'(tick),        32'(m_tick));
            chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
            chk("cfg_err",     32'(cfg_err),     32'(m_err));
            chk("cfg_ready",   32'(cfg_ready),   32'(model_ready(cfg_ch)));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        reset = 1'b1; ch_en = '1; sync_restart = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) step();
        chk("rst_clk",  32'(clk_out),     32'h0);
        chk("rst_tick", 32'(tick),        32'h0);
        chk("rst_pend", 32'(cfg_pending), 32'h0);
        reset = 1'b0;

        step();                                   // E1: first released edge
        chk("e1_clk",  32'(clk_out), 32'hF);
        chk("e1_tick", 32'(tick),    32'hF);
        step();                                   // E2
        chk("e2_clk",  32'(clk_out), 32'hF);
        chk("e2_tick", 32'(tick),    32'h0);
        step();                                   // E3
        chk("e3_clk",  32'(clk_out), 32'h0);
        step();                                   // E4
        chk("e4_clk",  32'(clk_out), 32'h0);
        step();                                   // E5: second period
        chk("e5_tick", 32'(tick),    32'hF);

        // ratio change ch1 -> 6, second request held off while pending
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd6;
        chk("rdy_free", 32'(cfg_ready), 32'd1);
        step();                                   // E6: accept
        chk("pend_set", 32'(cfg_pending), 32'h2);
        cfg_div = 8'd3;
        chk("rdy_busy", 32'(cfg_ready), 32'd0);
        step(); step();                           // E7, E8
        chk("ch1_old_e8", 32'(clk_out[1]), 32'd0);
        step();                                   // E9: wrap applies 6
        chk("ch1_wrap_clk", 32'(clk_out[1]), 32'd1);
        chk("pend_clr",     32'(cfg_pending), 32'h0);
        chk("rdy_again",    32'(cfg_ready),   32'd1);
        step();                                   // E10: held request accepted
        chk("pend_again", 32'(cfg_pending), 32'h2);

        // illegal requests: ratio 1, then channel 5
        cfg_ch = 3'd0; cfg_div = 8'd1;
        step();                                   // E11
        chk("err_div",    32'(cfg_err),     32'd1);
        chk("err_nopend", 32'(cfg_pending), 32'h2);
        chk("ch1_e11",    32'(clk_out[1]),  32'd1);
        cfg_ch = 3'd5; cfg_div = 8'd7;
        step();                                   // E12
        chk("err_ch",  32'(cfg_err),    32'd1);
        chk("ch1_e12", 32'(clk_out[1]), 32'd0);
        cfg_valid = 1'b0;
        step();                                   // E13: ch0/ch2 wrap
        chk("err_gone",    32'(cfg_err),    32'd0);
        chk("ch0_keep_n4", 32'(tick[0]),    32'd1);

        // stop ch2 right after its wrap
        ch_en[2] = 1'b0;
        step();                                   // E14
        chk("stop_e14", 32'(clk_out[2]), 32'd1);
        step(); step();                           // E15, E16
        step();                                   // E17: ch2 held
        chk("stop_hold_clk", 32'(clk_out[2]), 32'd0);
        chk("stop_tick",     32'(tick),       32'h9);
        step(); step();                           // E18, E19
        chk("stop_still", 32'(clk_out[2]), 32'd0);
        ch_en[2] = 1'b1;
        step();                                   // E20: resume
        chk("resume_clk",  32'(clk_out[2]), 32'd1);
        chk("resume_tick", 32'(tick[2]),    32'd1);

        // ch0 -> 2 (accepted on ch0's wrap edge), then realign
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2;
        step();
        cfg_valid = 1'b0;
        repeat (7) step();
        chk("pre_rs_pend", 32'(cfg_pending), 32'h0);

        sync_restart = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd5;
        step();                                   // R
        sync_restart = 1'b0; cfg_valid = 1'b0;
        chk("rs_clk",  32'(clk_out),     32'h0);
        chk("rs_tick", 32'(tick),        32'h0);
        chk("rs_pend", 32'(cfg_pending), 32'h4);
        step();                                   // R+1
        chk("rs1_clk",  32'(clk_out), 32'hF);
        chk("rs1_tick", 32'(tick),    32'hF);
        step();                                   // R+2
        chk("rs2_clk", 32'(clk_out), 32'hC);
        step();                                   // R+3
        chk("rs3_clk", 32'(clk_out), 32'h1);
        step();                                   // R+4
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd2;
        step();                                   // R+5: accept on ch3 wrap
        cfg_valid = 1'b0;
        chk("wrap_pend", 32'(cfg_pending), 32'h8);
        chk("wrap_tick", 32'(tick[3]),     32'd1);
        step();                                   // R+6: still N=4
        chk("wrap_defer", 32'(clk_out[3]), 32'd1);
        step(); step();                           // R+7, R+8
        step();                                   // R+9: apply N=2
        chk("wrap_apply_pend", 32'(cfg_pending), 32'h0);
        chk("wrap_apply_clk",  32'(clk_out[3]),  32'd1);
        step();                                   // R+10
        chk("n2_low",  32'(clk_out[3]), 32'd0);
        step();                                   // R+11
        chk("n2_high", 32'(clk_out[3]), 32'd1);

        // reset mid-period
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_clk",  32'(clk_out),     32'h0);
        chk("mid_rst_tick", 32'(tick),        32'h0);
        chk("mid_rst_pend", 32'(cfg_pending), 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_clk", 32'(clk_out), 32'hF);
        repeat (8) step();

        @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_domain_gen.md
# clk_domain_gen

Parametrised multi-channel clock generator for the processor top level. It derives NUM_CH divided clocks from the single board clock, one each for imem, dmem, regfile and processor. Each channel has a divide ratio that can be changed at run time without glitches, a per-channel stop/start control, and a global phase-realign command. It replaces fixed divide-by-2 and divide-by-4 dividers, and every output is a flop output.

## Interface
- NUM_CH, 4: number of output channels (1..16).
- CH_W, 2: width of cfg_ch; must be ≥ clog2(NUM_CH) and ≥ 1.
- DIV_W, 8: width of the divide-ratio fields.
- DEFAULT_DIV, 4: ratio loaded into every channel at reset; legal range 2..2^DIV_W−1.

Ports:
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable; 1 = run.
- sync_restart  in  1  one-cycle pulse that realigns all channels.
- cfg_valid  in  1  ratio-change request valid.
- cfg_ready  out  1  combinational; equals ~cfg_pending[cfg_ch]; 1 when cfg_ch ≥ NUM_CH.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  requested ratio.
- cfg_err  out  1  one-cycle pulse: an accepted request was illegal.
- cfg_pending  out  NUM_CH  ratio change waiting for the channel's next wrap.
- clk_out  out  NUM_CH  divided clocks.
- tick  out  NUM_CH  one-cycle pulse in the first cycle that clk_out is high in each period.

## Operation
Per-channel state:
- cnt: DIV_W-bit counter.
- div_cur: current ratio.
- div_pend: requested ratio.
- pend flag: drives cfg_pending.

Counter rule, given N = div_cur:
- cnt counts 0..N−1.
- The wrap edge is the edge where cnt goes from N−1 to 0.

Output decode, registered from the next value of cnt:
- clk_out = (cnt < N>>1).
- tick = (cnt == 0).
- Resulting waveforms:
  - N=4: 1,1,0,0.
  - N=3: 1,0,0.
  - N=2: 1,0.

Reset (reset sampled high):
- cnt = DEFAULT_DIV−1 and div_cur = DEFAULT_DIV.
- pend = 0, clk_out = 0, tick = 0, cfg_err = 0.

Run:
- A running channel wraps from N−1 to 0.
- At the wrap edge, if pend = 1, div_cur takes div_pend, pend clears, and the new period uses the new ratio.

Stop:
- If ch_en is 0 while cnt = N−1, the channel holds cnt at N−1.
- While held, clk_out = 0 and tick = 0.
- A stop therefore always completes the current period, so no runt pulses occur.
- A pending ratio is applied on the first held edge, and cnt becomes new_div−1.
- When ch_en returns to 1, the next edge wraps to 0.

Restart:
- When sync_restart = 1, every channel applies any pending ratio.
- Every channel sets cnt to div−1, and clk_out and tick go to 0.
- Enabled channels then rise together on the following edge.
- Restart overrides run and stop for that edge.

Configuration:
- A request is accepted when cfg_valid & cfg_ready.
- If cfg_div < 2 or cfg_ch ≥ NUM_CH, the request is accepted but dropped, and cfg_err pulses on the next cycle.
- Otherwise div_pend and pend are loaded at the accept edge.

Simultaneous events:
- An accept on a channel's wrap edge is not applied at that wrap; it applies at the following wrap.
- An accept coinciding with sync_restart is applied at the next restart or wrap, not at this one.
- Reset has priority over everything.
- Reset asserted mid-period truncates the period; clk_out is 0 after the reset edge.

## Timing
- All outputs except cfg_ready are flops; cfg_ready is combinational from cfg_ch and pend.
- First edge with reset low: enabled channels rise, so clk_out = 1 and tick = 1 after that edge.
- Ratio-change latency is from the accept edge to the first wrap edge that follows it, at most old N cycles.
- cfg_pending is high from the accept edge until the applying edge inclusive, then drops.
- Stop latency is 0 to N−1 cycles; restart from stop takes 1 cycle.
- sync_restart gives 1 low cycle, then all enabled channels rise on the same edge.

## Test plan
- Reset → defaults: hold reset 3 cycles, release with DEFAULT_DIV=4 and all ch_en=1 → every clk_out reads 1,1,0,0 repeating from the first released edge; tick is high every 4th cycle, starting on that edge.
- Glitch-free ratio change: mid-period (cnt=1), request ch1 cfg_div=6 → cfg_pending[1]=1; the current 4-cycle period completes; next period is 1,1,1,0,0,0; cfg_pending[1] clears at the wrap.
- Back-pressure on pending: issue a second request to ch1 while it is pending → cfg_ready=0 and no accept; the request is accepted the cycle after pend clears.
- Illegal requests: cfg_div=1, then cfg_ch=5 with NUM_CH=4 → each is accepted, cfg_err pulses once for each, and div_cur is unchanged.
- Stop/start: drop ch_en[2] at cnt=0 with N=4 → channel finishes 1,1,0,0, then holds 0 with no tick; raise ch_en → channel rises on the next edge.
- Realign and boundaries: set ch0 N=2 and ch1 N=3, out of phase, then pulse sync_restart → 1 low cycle, then both rise on the same edge. Also check an accept on the wrap edge (deferred by one period) and reset mid-period (clk_out=0 next cycle).
